// File: rtl/fpu_issue_sequencer.sv
// Issue/completion sequencer for a combinational FPU: registers operands, holds them for a
// per-op latency (multicycle paths), then returns the captured result over valid/ready.
module fpu_issue_sequencer #(
  parameter int unsigned ADD_LAT  = 1,
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_LAT  = 8,
  parameter int unsigned SGNJ_LAT = 1,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [2:0]  req_fpu_control,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  output logic [31:0] fpu_rs1,
  output logic [31:0] fpu_rs2,
  output logic [2:0]  fpu_control,
  output logic [2:0]  fpu_funct3,
  output logic        fpu_sel,
  input  logic [31:0] fpu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_rd,
  output logic        rsp_illegal,
  output logic        busy,
  output logic [31:0] op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  localparam logic [CNT_W-1:0] AddM1  = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] MulM1  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DivM1  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] SgnjM1 = CNT_W'(SGNJ_LAT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lat_m1;
  logic [4:0]       tag_q;
  logic             accept;
  logic             op_illegal;

  // Counter preload is latency minus one so LAT=1 captures on the first EXEC edge.
  always_comb begin
    lat_m1 = '0;
    case (req_fpu_control)
      3'b000, 3'b001: lat_m1 = AddM1;
      3'b010:         lat_m1 = MulM1;
      3'b011:         lat_m1 = DivM1;
      3'b100:         lat_m1 = SgnjM1;
      default:        lat_m1 = '0;
    endcase
  end

  assign req_ready  = rst_n & ~flush &
                      ((state_q == StIdle) | ((state_q == StDone) & rsp_ready));
  assign accept     = req_valid & req_ready;
  assign busy       = (state_q != StIdle);
  assign op_illegal = fpu_control[2] & (|fpu_control[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tag_q       <= '0;
      fpu_rs1     <= '0;
      fpu_rs2     <= '0;
      fpu_control <= '0;
      fpu_funct3  <= '0;
      fpu_sel     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_rd      <= '0;
      rsp_illegal <= 1'b0;
      op_count    <= '0;
    end else if (flush) begin
      state_q   <= StIdle;
      rsp_valid <= 1'b0;
    end else begin
      case (state_q)
        StIdle: ;
        StExec: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            rsp_result  <= op_illegal ? 32'd0 : fpu_result;
            rsp_rd      <= tag_q;
            rsp_illegal <= op_illegal;
            rsp_valid   <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            op_count  <= op_count + 32'd1;
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      // Accept can only happen in IDLE or on the DONE handshake edge; it overrides the
      // IDLE transition so back-to-back ops cost LAT+1 cycles.
      if (accept) begin
        fpu_rs1     <= req_rs1;
        fpu_rs2     <= req_rs2;
        fpu_control <= req_fpu_control;
        fpu_funct3  <= req_funct3;
        fpu_sel     <= (req_fpu_control == 3'b001);
        tag_q       <= req_rd;
        cnt_q       <= lat_m1;
        state_q     <= StExec;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Scoreboard bench for fpu_issue_sequencer: driver pushes expected responses, a negedge
// monitor pops and checks result, tag, illegal flag and latency; op_count tracked too.
module tb_fpu_issue_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [2:0]  req_fpu_control = '0;
  logic [2:0]  req_funct3 = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] fpu_rs1, fpu_rs2;
  logic [2:0]  fpu_control, fpu_funct3;
  logic        fpu_sel;
  logic [31:0] fpu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_rd;
  logic        rsp_illegal;
  logic        busy;
  logic [31:0] op_count;

  fpu_issue_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rs1        (req_rs1),
    .req_rs2        (req_rs2),
    .req_fpu_control(req_fpu_control),
    .req_funct3     (req_funct3),
    .req_rd         (req_rd),
    .fpu_rs1        (fpu_rs1),
    .fpu_rs2        (fpu_rs2),
    .fpu_control    (fpu_control),
    .fpu_funct3     (fpu_funct3),
    .fpu_sel        (fpu_sel),
    .fpu_result     (fpu_result),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_rd         (rsp_rd),
    .rsp_illegal    (rsp_illegal),
    .busy           (busy),
    .op_count       (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_cnt = '0;
  logic        prev_v = 1'b0;
  logic [31:0] held_res;
  logic [4:0]  held_rd;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in FPU: sign injection computed, arithmetic only for the directed operands.
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c, input logic [2:0] f);
    logic [31:0] r;
    r = 32'hDEADBEEF;
    case (c)
      3'b000: if (a == 32'h40400000 && b == 32'h40400000) r = 32'h40C00000;
      3'b001: if (a == b) r = 32'h00000000;
      3'b010: if (a == 32'hBF000000 && b == 32'h40CCCCCC) r = 32'hC04CCCCC;
      3'b011: if (a == 32'hC0CCCCCC && b == 32'hBF000000) r = 32'h414CCCCC;
      3'b100: begin
        case (f)
          3'b000:  r = {b[31], a[30:0]};
          3'b001:  r = {~b[31], a[30:0]};
          3'b010:  r = {a[31] ^ b[31], a[30:0]};
          default: r = 32'hDEADBEEF;
        endcase
      end
      default: r = 32'hFFFFFFFF;
    endcase
    return r;
  endfunction

  always_comb fpu_result = fpu_model(fpu_rs1, fpu_rs2, fpu_control, fpu_funct3);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Expected completion count from observed handshakes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_cnt <= '0;
    else if (!flush && rsp_valid && rsp_ready) exp_cnt <= exp_cnt + 32'd1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      chk("op_count", op_count, exp_cnt);
      if (rsp_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rd %0d result 0x%08h, required no response",
                   rsp_rd, rsp_result);
        end else begin
          e = sb.pop_front();
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_rd", 32'(rsp_rd), 32'(e.rd));
          chk("rsp_illegal", 32'(rsp_illegal), 32'(e.ill));
          chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
        held_res = rsp_result;
        held_rd  = rsp_rd;
      end else if (rsp_valid) begin
        chk("rsp_hold_result", rsp_result, held_res);
        chk("rsp_hold_rd", 32'(rsp_rd), 32'(held_rd));
      end
      prev_v = rsp_valid;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                       input logic [2:0] f, input logic [4:0] rd, input logic [31:0] er,
                       input logic ei, input int lat);
    int n;
    req_rs1 = a;
    req_rs2 = b;
    req_fpu_control = c;
    req_funct3 = f;
    req_rd = rd;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got req_ready 0 for rd %0d, required 1", rd);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    sb.push_back('{res: er, rd: rd, ill: ei, lat: lat, acc: cyc});
    req_valid = 1'b0;
    // Scramble request bus; latched operands must not follow.
    req_rs1 = 32'h12345678;
    req_rs2 = 32'h9ABCDEF0;
    req_fpu_control = 3'b111;
    req_funct3 = 3'b111;
    req_rd = 5'd31;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp", {26'd0, rsp_valid, rsp_rd}, 32'd0);
    chk("rst_op_count", op_count, 32'd0);
    chk("rst_fpu_rs1", fpu_rs1, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(32'hBF000000, 32'h40CCCCCC, 3'b100, 3'b000, 5'd5, 32'h3F000000, 1'b0, 1);
    issue(32'hBF000000, 32'h40CCCCCC, 3'b100, 3'b010, 5'd6, 32'hBF000000, 1'b0, 1);
    issue(32'h3F000000, 32'h3F000000, 3'b001, 3'b000, 5'd7, 32'h00000000, 1'b0, 1);
    @(negedge clk);
    chk("sub_fpu_sel", 32'(fpu_sel), 32'd1);
    chk("sub_fpu_control", 32'(fpu_control), 32'd1);

    // Divide: busy and not ready for all 8 cycles, even with a request pending.
    issue(32'hC0CCCCCC, 32'hBF000000, 3'b011, 3'b000, 5'd8, 32'h414CCCCC, 1'b0, 8);
    req_rs1 = 32'h40400000;
    req_rs2 = 32'h40400000;
    req_fpu_control = 3'b000;
    req_rd = 5'd20;
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) chk("div_fpu_sel", 32'(fpu_sel), 32'd0);
      chk("div_busy", 32'(busy), 32'd1);
      chk("div_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    drain();

    // Multiply with response back-pressure, then same-edge accept of the queued op.
    rsp_ready = 1'b0;
    issue(32'hBF000000, 32'h40CCCCCC, 3'b010, 3'b000, 5'd10, 32'hC04CCCCC, 1'b0, 2);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mul_rsp_seen", 32'(rsp_valid), 32'd1);
    req_rs1 = 32'h3F800000;
    req_rs2 = 32'h40000000;
    req_fpu_control = 3'b100;
    req_funct3 = 3'b001;
    req_rd = 5'd11;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(32'h3F800000, 32'h40000000, 3'b100, 3'b001, 5'd11, 32'hBF800000, 1'b0, 1);
    @(negedge clk);
    chk("b2b_rsp_dropped", 32'(rsp_valid), 32'd0);
    drain();

    // Flush a divide when cnt is 3; the request presented alongside must be refused.
    issue(32'hC0CCCCCC, 32'hBF000000, 3'b011, 3'b000, 5'd12, 32'h414CCCCC, 1'b0, 8);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    req_rs1 = 32'h40400000;
    req_rs2 = 32'h40400000;
    req_fpu_control = 3'b000;
    req_rd = 5'd21;
    req_valid = 1'b1;
    @(negedge clk);
    chk("flush_req_ready", 32'(req_ready), 32'd0);
    chk("flush_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_valid = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("flush_busy_after", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("flush_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;

    issue(32'h40400000, 32'h40400000, 3'b000, 3'b000, 5'd13, 32'h40C00000, 1'b0, 1);
    issue(32'h3F800000, 32'h3F800000, 3'b110, 3'b000, 5'd14, 32'h00000000, 1'b1, 1);
    drain();

    // Asynchronous reset in the middle of a divide.
    issue(32'hC0CCCCCC, 32'hBF000000, 3'b011, 3'b000, 5'd15, 32'h414CCCCC, 1'b0, 8);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_fpu_rs1", fpu_rs1, 32'd0);
    chk("arst_fpu_rs2", fpu_rs2, 32'd0);
    chk("arst_fpu_ctl", {25'd0, fpu_control, fpu_funct3, fpu_sel}, 32'd0);
    chk("arst_rsp", {25'd0, rsp_valid, rsp_illegal, rsp_rd}, 32'd0);
    chk("arst_rsp_result", rsp_result, 32'd0);
    chk("arst_op_count", op_count, 32'd0);
    chk("arst_ready_busy", {30'd0, req_ready, busy}, 32'd0);
    sb.delete();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(32'hBF000000, 32'h40CCCCCC, 3'b100, 3'b000, 5'd16, 32'h3F000000, 1'b0, 1);
    drain();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
